// File: rtl/traffic_pkg.sv
// Shared state codes and lamp encodings for the multi-approach traffic controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        RED_AMBER = 3'd1,
        GREEN     = 3'd2,
        AMBER     = 3'd3,
        WALK      = 3'd4
    } state_e;

    // Per-approach lamp triple is {green, amber, red}
    localparam logic [2:0] LAMP_RED       = 3'b001;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b011;
    localparam logic [2:0] LAMP_GREEN     = 3'b100;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable phase down-counter; elapsed reads 1 in the first cycle after a load
// and counts up (saturating) while the phase lasts.
module traffic_phase_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o,
    output logic [CNT_W-1:0] elapsed_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] elapsed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= RST_VAL;
            elapsed_q <= CNT_W'(1);
        end else if (load_i) begin
            count_q   <= load_val_i;
            elapsed_q <= CNT_W'(1);
        end else begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
            if (elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 1'b1;
            end
        end
    end

    assign zero_o    = (count_q == '0);
    assign elapsed_o = elapsed_q;

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic controller for NUM_DIR approaches with button-shortened green.
// Optional pedestrian walk phase is enabled by defining TRAFFIC_PED_WALK_EN.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR       = 2,
    parameter int CNT_W         = 16,
    parameter int GREEN_CYC     = 30,
    parameter int MIN_GREEN_CYC = 10,
    parameter int AMBER_CYC     = 3,
    parameter int RED_AMBER_CYC = 3,
    parameter int ALL_RED_CYC   = 2,
    parameter int WALK_CYC      = 8,
    localparam int DIR_W        = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   button,
    input  logic [NUM_DIR-1:0]     demand,
    output logic [3*NUM_DIR-1:0]   lights,
    output logic [DIR_W-1:0]       active_dir,
    output logic [2:0]             phase,
    output logic                   walk
);

    state_e                  state_q, state_d;
    logic [DIR_W-1:0]        dir_q, dir_d;
    logic                    btn_q, btn_d;
    logic [3*NUM_DIR-1:0]    lights_q;
    logic                    tmr_load;
    logic                    tmr_zero;
    logic [CNT_W-1:0]        tmr_elapsed;

    function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
        case (s)
            RED_AMBER: dur_m1 = CNT_W'(RED_AMBER_CYC - 1);
            GREEN:     dur_m1 = CNT_W'(GREEN_CYC - 1);
            AMBER:     dur_m1 = CNT_W'(AMBER_CYC - 1);
            WALK:      dur_m1 = CNT_W'(WALK_CYC - 1);
            default:   dur_m1 = CNT_W'(ALL_RED_CYC - 1);
        endcase
    endfunction

    // First demander after cur (wrapping); cur itself is only reached last
    function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0] cur,
                                                  input logic [NUM_DIR-1:0] dem);
        logic [DIR_W-1:0] idx;
        logic             found;
        idx      = cur;
        found    = 1'b0;
        next_dir = (cur == DIR_W'(NUM_DIR - 1)) ? '0 : cur + 1'b1;
        for (int i = 0; i < NUM_DIR; i++) begin
            idx = (idx == DIR_W'(NUM_DIR - 1)) ? '0 : idx + 1'b1;
            if (!found && dem[idx]) begin
                next_dir = idx;
                found    = 1'b1;
            end
        end
    endfunction

    function automatic logic [3*NUM_DIR-1:0] lamps(input state_e s, input logic [DIR_W-1:0] dir);
        lamps = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lamps[3*i +: 3] = LAMP_RED;
            if (DIR_W'(i) == dir) begin
                case (s)
                    RED_AMBER: lamps[3*i +: 3] = LAMP_RED_AMBER;
                    GREEN:     lamps[3*i +: 3] = LAMP_GREEN;
                    AMBER:     lamps[3*i +: 3] = LAMP_AMBER;
                    default:   lamps[3*i +: 3] = LAMP_RED;
                endcase
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            ALL_RED: begin
                if (tmr_zero) begin
`ifdef TRAFFIC_PED_WALK_EN
                    if (btn_q) begin
                        state_d = WALK;
                    end else begin
                        state_d = RED_AMBER;
                        dir_d   = next_dir(dir_q, demand);
                    end
`else
                    state_d = RED_AMBER;
                    dir_d   = next_dir(dir_q, demand);
`endif
                end
            end
            RED_AMBER: if (tmr_zero) state_d = GREEN;
            GREEN: begin
                if (tmr_zero || (btn_q && (tmr_elapsed >= CNT_W'(MIN_GREEN_CYC)))) begin
                    state_d = AMBER;
                end
            end
            AMBER:   if (tmr_zero) state_d = ALL_RED;
            WALK:    if (tmr_zero) state_d = ALL_RED;
            default: state_d = ALL_RED;
        endcase

        // Button is latched outside WALK; clearing on phase entry wins over a new press
        btn_d = btn_q | (button && (state_q != WALK));
`ifdef TRAFFIC_PED_WALK_EN
        if ((state_d == WALK) && (state_q != WALK)) btn_d = 1'b0;
`else
        if ((state_d == AMBER) && (state_q != AMBER)) btn_d = 1'b0;
`endif
    end

    assign tmr_load = (state_d != state_q);

    traffic_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALL_RED_CYC - 1))
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (dur_m1(state_d)),
        .zero_o     (tmr_zero),
        .elapsed_o  (tmr_elapsed)
    );

`ifdef TRAFFIC_PED_WALK_EN
    logic walk_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ALL_RED;
            dir_q    <= DIR_W'(NUM_DIR - 1);
            btn_q    <= 1'b0;
            lights_q <= {NUM_DIR{LAMP_RED}};
`ifdef TRAFFIC_PED_WALK_EN
            walk_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            btn_q    <= btn_d;
            lights_q <= lamps(state_d, dir_d);
`ifdef TRAFFIC_PED_WALK_EN
            walk_q   <= (state_d == WALK);
`endif
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    assign walk = walk_q;
`else
    assign walk = 1'b0;
`endif

    assign lights     = lights_q;
    assign active_dir = dir_q;
    assign phase      = state_q;

endmodule
